// File: rtl/fixed_point_act_fun_deriv.sv
// Backward pass of the piecewise tanh: VALUE_OUT = g * (1 - y^2) in signed fixed point,
// computed on one time-shared multiplier under a small handshaked FSM.
module fixed_point_act_fun_deriv #(
  parameter int WIDTH     = 16,
  parameter int FRAC_BITS = 13
) (
  input  logic                    CLK,
  input  logic                    RSTN,
  input  logic signed [WIDTH-1:0] VALUE_IN,
  input  logic signed [WIDTH-1:0] GRAD_IN,
  input  logic                    VALID_IN,
  output logic                    READY_OUT,
  output logic signed [WIDTH-1:0] VALUE_OUT,
  output logic                    SAT_OUT,
  output logic                    VALID_OUT,
  input  logic                    READY_IN
);

  localparam int PW = 2 * WIDTH;

  localparam logic [WIDTH-1:0]        W_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]        W_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [PW-1:0]    P_MAX = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0]    P_MIN = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH:0]   S_MAX = {2'b00, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH:0]   S_MIN = {2'b11, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH:0]   ONE   = {{(WIDTH-FRAC_BITS){1'b0}}, 1'b1, {FRAC_BITS{1'b0}}};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SQUARE = 3'd1,
    SUB    = 3'd2,
    SCALE  = 3'd3,
    OUT    = 3'd4
  } state_t;

  state_t state, state_nxt;

  // Returns {saturated, value}: floor-scaled product clamped to the WIDTH-bit range.
  function automatic logic [WIDTH:0] sat_prod(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] sh;
    sh = p >>> FRAC_BITS;
    if (sh > P_MAX)      sat_prod = {1'b1, W_MAX};
    else if (sh < P_MIN) sat_prod = {1'b1, W_MIN};
    else                 sat_prod = {1'b0, sh[WIDTH-1:0]};
  endfunction

  // Returns {saturated, value}: WIDTH+1-bit difference clamped to the WIDTH-bit range.
  function automatic logic [WIDTH:0] sat_sub(input logic signed [WIDTH:0] v);
    if (v > S_MAX)      sat_sub = {1'b1, W_MAX};
    else if (v < S_MIN) sat_sub = {1'b1, W_MIN};
    else                sat_sub = {1'b0, v[WIDTH-1:0]};
  endfunction

  logic signed [WIDTH-1:0] y_p0, g_p0;
  logic signed [PW-1:0]    prod_p1;
  logic signed [WIDTH-1:0] d_p2;
  logic                    sat_acc;
  logic                    scale_ph;

  logic signed [WIDTH-1:0] mul_a, mul_b;
  logic signed [PW-1:0]    mul_prod;
  logic [WIDTH:0]          prod_sat;
  logic signed [WIDTH:0]   s_ext;
  logic signed [WIDTH:0]   diff;
  logic [WIDTH:0]          sub_res;

  // Shared multiplier: squares y in SQUARE, scales g by d otherwise.
  always_comb begin
    mul_a = g_p0;
    mul_b = d_p2;
    if (state == SQUARE) begin
      mul_a = y_p0;
      mul_b = y_p0;
    end
  end

  assign mul_prod = PW'(mul_a) * PW'(mul_b);
  assign prod_sat = sat_prod(prod_p1);
  assign s_ext    = {prod_sat[WIDTH-1], prod_sat[WIDTH-1:0]};
  assign diff     = ONE - s_ext;
  assign sub_res  = sat_sub(diff);

  assign READY_OUT = (state == IDLE);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (VALID_IN) state_nxt = SQUARE;
      SQUARE:  state_nxt = SUB;
      SUB:     state_nxt = SCALE;
      SCALE:   if (scale_ph) state_nxt = OUT;
      OUT:     if (READY_IN) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      y_p0      <= '0;
      g_p0      <= '0;
      prod_p1   <= '0;
      d_p2      <= '0;
      sat_acc   <= 1'b0;
      scale_ph  <= 1'b0;
      VALUE_OUT <= '0;
      SAT_OUT   <= 1'b0;
      VALID_OUT <= 1'b0;
    end else begin
      case (state)
        // Stage p0: operand capture on acceptance
        IDLE: begin
          if (VALID_IN) begin
            y_p0     <= VALUE_IN;
            g_p0     <= GRAD_IN;
            sat_acc  <= 1'b0;
            scale_ph <= 1'b0;
          end
        end
        // Stage p1: raw y*y product
        SQUARE: prod_p1 <= mul_prod;
        // Stage p2: d = 1 - sat(y^2)
        SUB: begin
          d_p2    <= sub_res[WIDTH-1:0];
          sat_acc <= sat_acc | prod_sat[WIDTH] | sub_res[WIDTH];
        end
        // SCALE takes two cycles: product register, then saturate into the output register
        SCALE: begin
          if (!scale_ph) begin
            prod_p1  <= mul_prod;
            scale_ph <= 1'b1;
          end else begin
            VALUE_OUT <= prod_sat[WIDTH-1:0];
            SAT_OUT   <= sat_acc | prod_sat[WIDTH];
            VALID_OUT <= 1'b1;
            scale_ph  <= 1'b0;
          end
        end
        OUT: if (READY_IN) VALID_OUT <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_point_act_fun_deriv.sv
// Scoreboard bench for fixed_point_act_fun_deriv: directed vectors, backpressure,
// mid-operation reset and a randomized stream against a floor/saturate model.
module tb_fixed_point_act_fun_deriv;

  logic               CLK = 1'b0;
  logic               RSTN;
  logic signed [15:0] VALUE_IN, GRAD_IN;
  logic               VALID_IN;
  logic               READY_OUT;
  logic signed [15:0] VALUE_OUT;
  logic               SAT_OUT;
  logic               VALID_OUT;
  logic               READY_IN;

  fixed_point_act_fun_deriv #(.WIDTH(16), .FRAC_BITS(13)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .VALUE_IN(VALUE_IN), .GRAD_IN(GRAD_IN), .VALID_IN(VALID_IN), .READY_OUT(READY_OUT),
    .VALUE_OUT(VALUE_OUT), .SAT_OUT(SAT_OUT), .VALID_OUT(VALID_OUT), .READY_IN(READY_IN)
  );

  always #5 CLK = ~CLK;

  typedef struct { int val; bit sat; int acc; } exp_t;
  exp_t sb[$];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int sent = 0;
  int popped = 0;
  bit stream_done = 0;

  always @(posedge CLK) cyc++;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint clamp(input longint v, inout bit f);
    if (v > 32767)  begin f = 1; return 32767;  end
    if (v < -32768) begin f = 1; return -32768; end
    return v;
  endfunction

  // Reference: floor scaling via arithmetic shift of the exact product, then clamp.
  task automatic model(input int y, input int g, output int r, output bit s);
    longint sq, d, p;
    bit f;
    f = 0;
    sq = clamp((longint'(y) * longint'(y)) >>> 13, f);
    d  = clamp(longint'(8192) - sq, f);
    p  = clamp((longint'(g) * d) >>> 13, f);
    r = int'(p);
    s = f;
  endtask

  task automatic send(input int y, input int g, input int ev, input bit es);
    int n;
    exp_t e;
    @(negedge CLK);
    VALUE_IN = 16'(y);
    GRAD_IN  = 16'(g);
    VALID_IN = 1'b1;
    n = 0;
    while (!READY_OUT && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (!READY_OUT) begin
      chk("accept_timeout", 0, 1);
    end else begin
      e.val = ev; e.sat = es; e.acc = cyc + 1;
      sb.push_back(e);
      sent++;
    end
    @(negedge CLK);
    VALID_IN = 1'b0;
    VALUE_IN = 16'($urandom);
    GRAD_IN  = 16'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    chk("drain_pending", sb.size(), 0);
    repeat (2) @(negedge CLK);
  endtask

  task automatic set_rdy(input bit v);
    @(posedge CLK);
    #1 READY_IN = v;
  endtask

  // Monitor: latency, hold stability, handshake release and scoreboard compare.
  bit prev_v = 0, hs_prev = 0, prev_s = 0;
  int prev_val = 0;
  always @(negedge CLK) begin
    if (!RSTN) begin
      prev_v = 0;
      hs_prev = 0;
    end else begin
      if (hs_prev) begin
        chk("valid_drop", VALID_OUT, 0);
        chk("ready_back", READY_OUT, 1);
        hs_prev = 0;
      end
      if (VALID_OUT && !prev_v) begin
        if (sb.size() == 0) chk("spurious_valid", 1, 0);
        else chk("latency", cyc - sb[0].acc, 4);
      end
      if (VALID_OUT && prev_v) begin
        chk("hold_value", VALUE_OUT, prev_val);
        chk("hold_sat", SAT_OUT, prev_s);
      end
      if (VALID_OUT && READY_IN && sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        popped++;
        chk("value", VALUE_OUT, e.val);
        chk("sat", SAT_OUT, e.sat);
        hs_prev = 1;
      end
      prev_v = VALID_OUT;
      prev_val = int'(VALUE_OUT);
      prev_s = SAT_OUT;
    end
  end

  int dy[10] = '{0, 4096, -4096, 8192, 4096, -32768, 16384, 32767, 100, 1};
  int dg[10] = '{8192, 8192, 8192, 8192, -8192, 16384, 8192, 0, -3, 1};
  int dr[10] = '{8192, 6144, 6144, 0, -6144, -32768, -24575, 0, -3, 1};
  bit ds[10] = '{0, 0, 0, 0, 0, 1, 1, 1, 0, 0};

  initial begin
    int n, r, y, g, gap;
    bit s;
    RSTN = 1'b0; VALID_IN = 1'b0; READY_IN = 1'b1;
    VALUE_IN = '0; GRAD_IN = '0;
    repeat (3) @(negedge CLK);
    chk("rst_ready", READY_OUT, 1);
    chk("rst_valid", VALID_OUT, 0);
    chk("rst_value", VALUE_OUT, 0);
    chk("rst_sat", SAT_OUT, 0);
    #2 RSTN = 1'b1;

    for (int i = 0; i < 10; i++) send(dy[i], dg[i], dr[i], ds[i]);
    drain();

    // Backpressure with a competing request while the result is held
    set_rdy(0);
    send(1234, 5000, 4887, 0);
    n = 0;
    while (!VALID_OUT && n < 50) begin @(negedge CLK); n++; end
    chk("bp_valid_seen", VALID_OUT, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      VALID_IN = 1'b1;
      VALUE_IN = 16'sd2000;
      GRAD_IN  = 16'sd3000;
      chk("bp_ready_low", READY_OUT, 0);
      chk("bp_valid_held", VALID_OUT, 1);
    end
    @(negedge CLK);
    VALID_IN = 1'b0;
    set_rdy(1);
    drain();
    chk("bp_no_extra", popped, sent);

    // Reset during SUB discards the operation
    send(4096, 8192, 6144, 0);
    @(negedge CLK);
    #2 RSTN = 1'b0;
    sb.delete();
    sent--;
    #1;
    chk("midrst_ready", READY_OUT, 1);
    chk("midrst_valid", VALID_OUT, 0);
    chk("midrst_value", VALUE_OUT, 0);
    chk("midrst_sat", SAT_OUT, 0);
    @(negedge CLK);
    #2 RSTN = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      chk("midrst_quiet", VALID_OUT, 0);
    end
    send(-4096, -8192, -6144, 0);
    drain();

    // Random stream with random gaps on both handshakes
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          gap = $urandom_range(0, 3);
          repeat (gap) @(negedge CLK);
          y = int'($signed(16'($urandom)));
          g = int'($signed(16'($urandom)));
          model(y, g, r, s);
          send(y, g, r, s);
        end
        stream_done = 1;
      end
      begin
        while (!stream_done) begin
          @(posedge CLK);
          #1 READY_IN = ($urandom_range(0, 3) != 0);
        end
      end
    join
    set_rdy(1);
    drain();
    chk("stream_count", popped, sent);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
